// File: rtl/sipo_pkg.sv
// Shared types and line-level constants for the serial-to-parallel frame receiver.
// Optional parity support is selected with the SIPO_PARITY_EN macro.
package sipo_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/sipo_shift_reg.sv
// MSB-first serial shift register with shift enable and parallel read-out.
module sipo_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en_i,
   input  logic             serial_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] sr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else if (shift_en_i) begin
         sr_q <= {sr_q[WIDTH-2:0], serial_i};
      end
   end

   assign data_o = sr_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer around sipo_shift_reg: start/data/[parity]/stop, single-entry output buffer.
// Define SIPO_PARITY_EN to add an even-parity bit after the data bits.
module sipo_frame_ctrl
   import sipo_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int BITCNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] p_data,
   output logic             p_valid,
   input  logic             p_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun,
   output logic             parity_err
);

   localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(WIDTH - 1);

   state_e              state_q, state_d;
   logic [BITCNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]    data_q, data_d;
   logic [WIDTH-1:0]    sr_word;
   logic                valid_q, valid_d;
   logic                frame_err_q, frame_err_d;
   logic                overrun_q, overrun_d;
   logic                shift_en;
   logic                stop_ok;
   logic                parity_ok;

   sipo_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_en_i(shift_en),
      .serial_i  (serial_in),
      .data_o    (sr_word)
   );

   assign stop_ok = (serial_in == STOP_LVL);

`ifdef SIPO_PARITY_EN
   logic par_q, par_d;
   logic parity_err_q, parity_err_d;

   assign parity_ok  = ~(^{sr_word, par_q});
   assign parity_err = parity_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
      end
   end
`else
   assign parity_ok  = 1'b1;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // The consumer handshake is evaluated every cycle, independent of bit_en,
   // so a stalled consumer never stalls the receive path.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      shift_en    = 1'b0;
`ifdef SIPO_PARITY_EN
      par_d        = par_q;
      parity_err_d = 1'b0;
`endif

      if (valid_q && p_ready) begin
         valid_d = 1'b0;
      end

      if (bit_en) begin
         case (state_q)
            S_IDLE: begin
               if (serial_in == START_LVL) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               shift_en = 1'b1;
               if (cnt_q == LAST_BIT) begin
                  cnt_d = '0;
`ifdef SIPO_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  cnt_d = cnt_q + BITCNT_W'(1);
               end
            end
`ifdef SIPO_PARITY_EN
            S_PARITY: begin
               par_d   = serial_in;
               state_d = S_STOP;
            end
`endif
            S_STOP: begin
               state_d     = S_IDLE;
               frame_err_d = ~stop_ok;
`ifdef SIPO_PARITY_EN
               parity_err_d = ~parity_ok;
`endif
               // A full buffer with no same-cycle transfer drops the new word.
               if (stop_ok && parity_ok) begin
                  if (valid_q && !p_ready) begin
                     overrun_d = 1'b1;
                  end else begin
                     data_d  = sr_word;
                     valid_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign p_data    = data_q;
   assign p_valid   = valid_q;
   assign busy      = (state_q != S_IDLE);
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: directed frames then random frames against a frame-level model.
// Honours SIPO_PARITY_EN the same way as the design.
module tb_sipo_frame_ctrl;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             bit_en;
   logic             serial_in;
   logic [WIDTH-1:0] p_data;
   logic             p_valid;
   logic             p_ready;
   logic             busy;
   logic             frame_err;
   logic             overrun;
   logic             parity_err;

   int checks;
   int errors;

   logic             expValid;
   logic [WIDTH-1:0] expData;
   logic             expBusy;
   logic             expFe;
   logic             expOv;
   logic             expPe;
   string            curTag;

   sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_en    (bit_en),
      .serial_in (serial_in),
      .p_data    (p_data),
      .p_valid   (p_valid),
      .p_ready   (p_ready),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .parity_err(parity_err)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkValue(input string tag, input logic [WIDTH-1:0] observed, input logic [WIDTH-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Compare every DUT output against the frame-level model.
   task automatic checkOutput();
      checkValue({curTag, ":p_valid"},    WIDTH'(p_valid),    WIDTH'(expValid));
      checkValue({curTag, ":p_data"},     p_data,             expData);
      checkValue({curTag, ":busy"},       WIDTH'(busy),       WIDTH'(expBusy));
      checkValue({curTag, ":frame_err"},  WIDTH'(frame_err),  WIDTH'(expFe));
      checkValue({curTag, ":overrun"},    WIDTH'(overrun),    WIDTH'(expOv));
      checkValue({curTag, ":parity_err"}, WIDTH'(parity_err), WIDTH'(expPe));
   endtask

   function automatic logic rdyFor(input int mode, input bit isStop);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return 1'($urandom % 2);
         default: return isStop;
      endcase
   endfunction

   // One clock: drive inputs at negedge, advance the model, check after posedge.
   task automatic applyStimulus(input logic be, input logic sin, input logic rdy,
                                input bit stopEvt, input logic [WIDTH-1:0] word,
                                input bit stopBit, input bit parBad, input bit busyAfter);
      logic xfer;
      @(negedge clk);
      bit_en    = be;
      serial_in = sin;
      p_ready   = rdy;
      xfer  = expValid && rdy;
      expFe = 1'b0;
      expOv = 1'b0;
      expPe = 1'b0;
      if (stopEvt) begin
         expFe = !stopBit;
         expPe = parBad;
         if (stopBit && !parBad) begin
            if (expValid && !rdy) begin
               expOv = 1'b1;
            end else begin
               expData  = word;
               expValid = 1'b1;
            end
         end else if (xfer) begin
            expValid = 1'b0;
         end
      end else if (xfer) begin
         expValid = 1'b0;
      end
      expBusy = busyAfter;
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic idleCycles(input int n, input int rdyMode);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'($urandom % 2), 1'b1, rdyFor(rdyMode, 1'b0), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
   endtask

   // Sends start + data (MSB first) + [parity] + stop, with 'gap' disabled cycles before each sample.
   task automatic sendFrame(input logic [WIDTH-1:0] word, input bit stopBit, input bit parFlip,
                            input int gap, input int rdyMode);
      logic bits[$];
      bit   parBad;
      bit   isStop;
      bits.delete();
      bits.push_back(1'b0);
      for (int i = WIDTH - 1; i >= 0; i--) bits.push_back(word[i]);
`ifdef SIPO_PARITY_EN
      bits.push_back((^word) ^ parFlip);
      parBad = parFlip;
`else
      parBad = 1'b0;
`endif
      bits.push_back(stopBit);
      for (int i = 0; i < bits.size(); i++) begin
         isStop = (i == bits.size() - 1);
         for (int g = 0; g < gap; g++) begin
            applyStimulus(1'b0, 1'($urandom % 2), rdyFor(rdyMode, 1'b0), 1'b0, word, stopBit, parBad, (i > 0));
         end
         applyStimulus(1'b1, bits[i], rdyFor(rdyMode, isStop), isStop, word, stopBit, parBad, !isStop);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bit_en    = 1'b0;
      serial_in = 1'b1;
      p_ready   = 1'b0;
      expValid  = 1'b0;
      expData   = '0;
      expBusy   = 1'b0;
      expFe     = 1'b0;
      expOv     = 1'b0;
      expPe     = 1'b0;

      $display("[TB] reset state");
      curTag = "reset";
      repeat (2) @(posedge clk);
      #1;
      checkOutput();
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] basic frame and handshake");
      curTag = "basic";
      idleCycles(2, 0);
      sendFrame(4'b1011, 1'b1, 1'b0, 0, 0);
      checkValue("basic_word", p_data, 4'b1011);
      checkValue("basic_valid", WIDTH'(p_valid), WIDTH'(1));
      idleCycles(3, 0);
      idleCycles(1, 1);
      checkValue("basic_drained", WIDTH'(p_valid), WIDTH'(0));

      $display("[TB] framing error then recovery");
      curTag = "frame_err";
      sendFrame(4'b1011, 1'b0, 1'b0, 0, 1);
      checkValue("ferr_pulse", WIDTH'(frame_err), WIDTH'(1));
      idleCycles(1, 1);
      sendFrame(4'b0110, 1'b1, 1'b0, 0, 0);
      checkValue("ferr_next_word", p_data, 4'b0110);
      idleCycles(1, 1);

      $display("[TB] overrun and same-cycle transfer");
      curTag = "overrun";
      sendFrame(4'b1011, 1'b1, 1'b0, 0, 0);
      sendFrame(4'b0001, 1'b1, 1'b0, 0, 0);
      checkValue("ovr_pulse", WIDTH'(overrun), WIDTH'(1));
      checkValue("ovr_kept", p_data, 4'b1011);
      sendFrame(4'b0001, 1'b1, 1'b0, 0, 3);
      checkValue("xfer_commit_word", p_data, 4'b0001);
      checkValue("xfer_commit_ovr", WIDTH'(overrun), WIDTH'(0));
      idleCycles(2, 1);

      $display("[TB] sparse bit_en");
      curTag = "sparse";
      sendFrame(4'b1100, 1'b1, 1'b0, 2, 2);
      idleCycles(2, 1);
      checkValue("sparse_word", p_data, 4'b1100);

      $display("[TB] reset mid-frame");
      curTag = "midreset";
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      expValid = 1'b0;
      expData  = '0;
      expBusy  = 1'b0;
      expFe    = 1'b0;
      expOv    = 1'b0;
      expPe    = 1'b0;
      checkOutput();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      idleCycles(1, 0);
      sendFrame(4'b0101, 1'b1, 1'b0, 0, 0);
      checkValue("midreset_word", p_data, 4'b0101);
      idleCycles(1, 1);

`ifdef SIPO_PARITY_EN
      $display("[TB] parity");
      curTag = "parity";
      sendFrame(4'b1011, 1'b1, 1'b0, 0, 0);
      checkValue("parity_ok_word", p_data, 4'b1011);
      idleCycles(1, 1);
      sendFrame(4'b1011, 1'b1, 1'b1, 0, 1);
      checkValue("parity_bad_pulse", WIDTH'(parity_err), WIDTH'(1));
      checkValue("parity_bad_valid", WIDTH'(p_valid), WIDTH'(0));
      idleCycles(1, 1);
`endif

      $display("[TB] random frames");
      curTag = "random";
      for (int n = 0; n < 40; n++) begin
         sendFrame(WIDTH'($urandom), (($urandom % 5) != 0), (($urandom % 4) == 0),
                   int'($urandom % 3), int'($urandom % 4));
         idleCycles(int'($urandom % 3), int'($urandom % 3));
      end
      idleCycles(2, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
